// File: rtl/kbd_pkg.sv
// rtl/kbd_pkg.sv - shared keyboard UART types, constants and baud divider helper
package kbd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_IDLE
    } uart_state_t;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 8;
    localparam int DATA_BITS  = 8;

    // Clocks per oversample tick, rounded to nearest and never below 1.
    function automatic int calc_div(input int clk_freq, input int baud);
        int d;
        d = (clk_freq + (baud * OVERSAMPLE) / 2) / (baud * OVERSAMPLE);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - oversample tick divider with enable and synchronous clear
module uart_baud_tick #(
    parameter int DIV = 27
) (
    input  logic clock,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/uart_rx_frame.sv
// rtl/uart_rx_frame.sv - 8N1 UART receiver with majority sampling and valid/ready output
module uart_rx_frame
    import kbd_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD);
    localparam logic [3:0] S_PRE  = 4'(MID_SAMPLE - 1);
    localparam logic [3:0] S_MID  = 4'(MID_SAMPLE);
    localparam logic [3:0] S_POST = 4'(MID_SAMPLE + 1);
    localparam logic [3:0] S_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [2:0] B_LAST = 3'(DATA_BITS - 1);

    uart_state_t state;
    logic        rx_meta, rs;
    logic        tick;
    logic [3:0]  scnt;
    logic [3:0]  hcnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic        s_pre, s_mid;
    logic        done;
    logic        vote;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rs      <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rs      <= rx_meta;
        end
    end

    // Divider is held cleared while idle so sampling phase follows the start edge.
    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clock(clock),
        .reset(reset),
        .en   (state != ST_IDLE),
        .clr  (state == ST_IDLE),
        .tick (tick)
    );

    assign vote = (s_pre & s_mid) | (s_pre & rs) | (s_mid & rs);
    assign busy = (state != ST_IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            scnt      <= '0;
            hcnt      <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            s_pre     <= 1'b1;
            s_mid     <= 1'b1;
            done      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            done      <= 1'b0;
            frame_err <= 1'b0;
            if (tick && scnt == S_PRE) s_pre <= rs;
            if (tick && scnt == S_MID) s_mid <= rs;
            case (state)
                ST_IDLE: begin
                    if (!rs) begin
                        state <= ST_START;
                        scnt  <= '0;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        scnt <= scnt + 4'd1;
                        if (scnt == S_MID && rs) begin
                            state <= ST_IDLE;
                        end else if (scnt == S_LAST) begin
                            state   <= ST_DATA;
                            bit_idx <= '0;
                        end
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        scnt <= scnt + 4'd1;
                        if (scnt == S_POST) shreg <= {vote, shreg[7:1]};
                        if (scnt == S_LAST) begin
                            if (bit_idx == B_LAST) state <= ST_STOP;
                            else bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        scnt <= scnt + 4'd1;
                        // Leave at mid-stop so a following start bit is not missed.
                        if (scnt == S_POST) begin
                            if (vote) begin
                                done  <= 1'b1;
                                state <= ST_IDLE;
                            end else begin
                                frame_err <= 1'b1;
                                hcnt      <= '0;
                                state     <= ST_WAIT_IDLE;
                            end
                        end
                    end
                end
                ST_WAIT_IDLE: begin
                    if (tick) begin
                        if (!rs) hcnt <= '0;
                        else if (hcnt == S_LAST) state <= ST_IDLE;
                        else hcnt <= hcnt + 4'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data    <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (done) begin
                if (!valid || ready) begin
                    data  <= shreg;
                    valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb/tb_uart_rx_frame.sv - scoreboard bench for uart_rx_frame at 16 clocks per bit
module tb_uart_rx_frame;

    logic       clock = 1'b0;
    logic       reset;
    logic       rxd;
    logic       ready;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int         total = 0;
    int         bad = 0;
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    logic [7:0] exp_q[$];

    always #5 clock = ~clock;

    uart_rx_frame #(.CLK_FREQ(1_600_000), .BAUD(100_000)) dut (
        .clock    (clock),
        .reset    (reset),
        .rxd      (rxd),
        .data     (data),
        .valid    (valid),
        .ready    (ready),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every accepted byte must match the head of the queue.
    always @(negedge clock) begin
        if (!reset) begin
            if (valid && ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rx_unexpected: got %0h expected none", data);
                end else begin
                    check("rx_data", {24'd0, data}, {24'd0, exp_q.pop_front()});
                end
            end
            if (frame_err) fe_cnt++;
            if (overrun) ov_cnt++;
            if (frame_err || overrun) check("err_exclusive", {31'd0, frame_err && overrun}, 32'd0);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Drives n clocks of a frame; glitch is a clock offset whose level is inverted (-1 for none).
    task automatic send_part(input logic [7:0] b, input logic stop, input int glitch, input int n);
        logic [159:0] wave;
        for (int i = 0; i < 160; i++) begin
            if (i < 16) wave[i] = 1'b0;
            else if (i < 144) wave[i] = b[(i / 16) - 1];
            else wave[i] = stop;
            if (i == glitch) wave[i] = ~wave[i];
        end
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
            rxd = wave[i];
        end
    endtask

    task automatic send(input logic [7:0] b, input logic stop, input int glitch);
        send_part(b, stop, glitch, 160);
    endtask

    initial begin
        int bc;
        int fe0;
        int ov0;

        reset = 1'b1;
        rxd   = 1'b1;
        ready = 1'b1;
        tick(3);
        check("rst_data", {24'd0, data}, 32'h0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        tick(5);

        // Single byte
        exp_q.push_back(8'hA5);
        send(8'hA5, 1'b1, -1);
        tick(20);
        check("a5_drain", exp_q.size(), 32'd0);
        check("a5_frame_err", fe_cnt, 32'd0);
        check("a5_overrun", ov_cnt, 32'd0);

        // Back-to-back frames with a single stop bit
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h55);
        send(8'h00, 1'b1, -1);
        send(8'hFF, 1'b1, -1);
        send(8'h55, 1'b1, -1);
        tick(20);
        check("b2b_drain", exp_q.size(), 32'd0);

        // Start-bit glitch of 4 clocks
        bc = 0;
        for (int i = 0; i < 34; i++) begin
            @(posedge clock);
            #1;
            rxd = (i < 4) ? 1'b0 : 1'b1;
            if (busy) bc++;
        end
        check("glitch_busy_seen", {31'd0, bc > 0}, 32'd1);
        check("glitch_busy_max9", {31'd0, bc <= 9}, 32'd1);
        check("glitch_busy_end", {31'd0, busy}, 32'd0);
        check("glitch_frame_err", fe_cnt, 32'd0);

        // Framing error followed by a held-low line and recovery
        fe0 = fe_cnt;
        send(8'h3C, 1'b0, -1);
        tick(40);
        check("fe_pulse_once", fe_cnt, fe0 + 1);
        check("fe_busy_low_line", {31'd0, busy}, 32'd1);
        rxd = 1'b1;
        tick(10);
        check("fe_busy_recovering", {31'd0, busy}, 32'd1);
        tick(10);
        check("fe_busy_recovered", {31'd0, busy}, 32'd0);
        exp_q.push_back(8'h81);
        send(8'h81, 1'b1, -1);
        tick(20);
        check("fe_next_drain", exp_q.size(), 32'd0);
        check("fe_total", fe_cnt, fe0 + 1);

        // Overrun while the consumer stalls
        ready = 1'b0;
        ov0 = ov_cnt;
        exp_q.push_back(8'h11);
        send(8'h11, 1'b1, -1);
        send(8'h22, 1'b1, -1);
        tick(20);
        check("ovr_valid_held", {31'd0, valid}, 32'd1);
        check("ovr_data_kept", {24'd0, data}, 32'h11);
        check("ovr_pulse_once", ov_cnt, ov0 + 1);
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        check("ovr_valid_cleared", {31'd0, valid}, 32'd0);
        check("ovr_drain", exp_q.size(), 32'd0);
        ready = 1'b1;

        // Majority vote masks a single bad sample (bit 3 high-going, bit 5 low-going)
        exp_q.push_back(8'hF0);
        exp_q.push_back(8'hF0);
        send(8'hF0, 1'b1, 16 * 4 + 10);
        send(8'hF0, 1'b1, 16 * 6 + 10);
        tick(20);
        check("maj_drain", exp_q.size(), 32'd0);

        // Reset in the middle of a frame while a byte is pending
        ready = 1'b0;
        send(8'h5A, 1'b1, -1);
        tick(20);
        check("rstmid_pending_valid", {31'd0, valid}, 32'd1);
        check("rstmid_pending_data", {24'd0, data}, 32'h5A);
        send_part(8'hC3, 1'b1, -1, 16 * 5 + 8);
        check("rstmid_busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        tick(2);
        check("rstmid_data", {24'd0, data}, 32'h0);
        check("rstmid_valid", {31'd0, valid}, 32'd0);
        check("rstmid_busy", {31'd0, busy}, 32'd0);
        check("rstmid_frame_err", {31'd0, frame_err}, 32'd0);
        check("rstmid_overrun", {31'd0, overrun}, 32'd0);
        rxd = 1'b1;
        reset = 1'b0;
        tick(40);
        check("rstmid_valid_after", {31'd0, valid}, 32'd0);
        check("rstmid_busy_after", {31'd0, busy}, 32'd0);
        ready = 1'b1;
        tick(5);
        check("final_drain", exp_q.size(), 32'd0);
        check("final_overrun_total", ov_cnt, ov0 + 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
